// File: rtl/digit_result_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_result_filter_pkg
// Purpose  : Shared types and constants for the digit result filter:
//            publish-state encoding, blanking code, digit range limit,
//            counter widths and saturating-increment helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package digit_result_filter_pkg;

   typedef enum logic [0:0] {
      ST_BLANK  = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
   localparam logic [3:0] MAX_DIGIT      = 4'd9;
   localparam int         MATCH_W        = 4;
   localparam int         MISS_W         = 8;

   function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] v);
      return (&v) ? v : v + MATCH_W'(1);
   endfunction

   function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] v);
      return (&v) ? v : v + MISS_W'(1);
   endfunction

endpackage : digit_result_filter_pkg
`default_nettype wire

// File: rtl/digit_result_filter_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : digit_frame_capture
// Purpose  : Accumulates the recognition core's detections over one frame.
//            Out-of-range digits are discarded; the last valid detection in
//            a frame wins. Capture clears on the cycle after frame end.
// Ports    : i_clk, i_rst          - clock, async active-high reset
//            i_frame_end           - end-of-frame pulse
//            i_det_valid/i_det_digit - raw detection strobe and digit
//            o_frame_has_det       - frame contains a valid detection
//            o_frame_digit         - digit of that detection
// Revision : 1.0 - initial release
// ============================================================================
module digit_frame_capture
   import digit_result_filter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_frame_end,
   input  logic       i_det_valid,
   input  logic [3:0] i_det_digit,
   output logic       o_frame_has_det,
   output logic [3:0] o_frame_digit
);

   logic       r_has_det;
   logic [3:0] r_digit;
   logic       w_take;

   assign w_take = i_det_valid && (i_det_digit <= MAX_DIGIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_has_det <= 1'b0;
         r_digit   <= 4'd0;
      end else if (i_frame_end) begin
         r_has_det <= 1'b0;
         r_digit   <= 4'd0;
      end else if (w_take) begin
         r_has_det <= 1'b1;
         r_digit   <= i_det_digit;
      end
   end

   // A detection coincident with frame_end belongs to the ending frame, so
   // the evaluated view merges the live strobe over the stored capture.
   assign o_frame_has_det = r_has_det | w_take;
   assign o_frame_digit   = w_take ? i_det_digit : r_digit;

endmodule : digit_frame_capture
`default_nettype wire

// File: rtl/digit_result_filter.sv
`default_nettype none
// ============================================================================
// Module   : digit_result_filter
// Purpose  : Debounces per-frame digit classifications before they reach the
//            seven-segment driver. A digit is published after STABLE_CNT
//            consecutive matching frames; the display blanks after
//            TIMEOUT_FRAMES consecutive empty frames (0 disables timeout).
//            Optional macro DIGIT_RESULT_FREEZE_EN adds a 'freeze' input that
//            holds the published result and state while counters still run.
// Ports    : CLK_50M        - 50 MHz system clock
//            RST            - async active-high reset
//            freeze         - (DIGIT_RESULT_FREEZE_EN only) hold outputs
//            frame_end      - end-of-frame pulse
//            det_valid      - detection strobe
//            det_digit      - detected digit
//            result         - published digit or BLANK_CODE
//            result_valid   - high while a digit is published
//            result_changed - one-cycle pulse when result changes
// Revision : 1.0 - initial release
// ============================================================================
module digit_result_filter
   import digit_result_filter_pkg::*;
#(
   parameter int unsigned STABLE_CNT     = 3,
   parameter int unsigned TIMEOUT_FRAMES = 30,
   parameter logic [3:0]  BLANK_CODE     = BLANK_CODE_DEF
) (
   input  logic       CLK_50M,
   input  logic       RST,
`ifdef DIGIT_RESULT_FREEZE_EN
   input  logic       freeze,
`endif
   input  logic       frame_end,
   input  logic       det_valid,
   input  logic [3:0] det_digit,
   output logic [3:0] result,
   output logic       result_valid,
   output logic       result_changed
);

   localparam logic [MATCH_W-1:0] c_STABLE_CNT = MATCH_W'(STABLE_CNT);
   localparam logic [MISS_W-1:0]  c_TIMEOUT    = MISS_W'(TIMEOUT_FRAMES);
   localparam bit                 c_TIMEOUT_EN = (TIMEOUT_FRAMES != 0);

   state_t               r_state, w_state_nxt;
   logic [3:0]           r_result, w_result_nxt;
   logic                 r_valid, w_valid_nxt;
   logic                 r_changed, w_changed_nxt;
   logic [3:0]           r_cand, w_cand_nxt;
   logic [MATCH_W-1:0]   r_match, w_match_nxt;
   logic [MISS_W-1:0]    r_miss, w_miss_nxt;

   logic                 w_has_det;
   logic [3:0]           w_digit;
   logic                 w_freeze;
   logic [MATCH_W-1:0]   w_track_cnt;
   logic [MISS_W-1:0]    w_miss_inc;
   logic                 w_stable;
   logic                 w_timeout;

`ifdef DIGIT_RESULT_FREEZE_EN
   assign w_freeze = freeze;
`else
   assign w_freeze = 1'b0;
`endif

   digit_frame_capture u_capture (
      .i_clk           (CLK_50M),
      .i_rst           (RST),
      .i_frame_end     (frame_end),
      .i_det_valid     (det_valid),
      .i_det_digit     (det_digit),
      .o_frame_has_det (w_has_det),
      .o_frame_digit   (w_digit)
   );

   // Candidate tracking: a repeat of the candidate extends the run, anything
   // else restarts it at one.
   assign w_track_cnt = (w_digit == r_cand) ? match_inc(r_match) : MATCH_W'(1);
   assign w_miss_inc  = miss_inc(r_miss);
   // '>=' rather than '==' so a threshold reached while frozen stays pending
   // and fires on the first unfrozen frame.
   assign w_stable    = (w_track_cnt >= c_STABLE_CNT);
   assign w_timeout   = c_TIMEOUT_EN && (w_miss_inc >= c_TIMEOUT);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_state <= ST_BLANK;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------- datapath regs
   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         r_result  <= BLANK_CODE;
         r_valid   <= 1'b0;
         r_changed <= 1'b0;
         r_cand    <= 4'd0;
         r_match   <= '0;
         r_miss    <= '0;
      end else begin
         r_result  <= w_result_nxt;
         r_valid   <= w_valid_nxt;
         r_changed <= w_changed_nxt;
         r_cand    <= w_cand_nxt;
         r_match   <= w_match_nxt;
         r_miss    <= w_miss_nxt;
      end
   end

   // --------------------------------------------------------- next-state comb
   always_comb begin
      w_state_nxt   = r_state;
      w_result_nxt  = r_result;
      w_valid_nxt   = r_valid;
      w_changed_nxt = 1'b0;
      w_cand_nxt    = r_cand;
      w_match_nxt   = r_match;
      w_miss_nxt    = r_miss;

      if (frame_end) begin
         case (r_state)
            ST_BLANK: begin
               if (w_has_det) begin
                  w_cand_nxt  = w_digit;
                  w_match_nxt = w_track_cnt;
                  if (w_stable && !w_freeze) begin
                     w_state_nxt   = ST_LOCKED;
                     w_result_nxt  = w_digit;
                     w_valid_nxt   = 1'b1;
                     w_changed_nxt = (w_digit != r_result);
                     w_match_nxt   = '0;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end

            ST_LOCKED: begin
               if (w_has_det) begin
                  w_miss_nxt = '0;
                  if (w_digit == r_result) begin
                     w_match_nxt = '0;
                  end else begin
                     w_cand_nxt  = w_digit;
                     w_match_nxt = w_track_cnt;
                     if (w_stable && !w_freeze) begin
                        w_result_nxt  = w_digit;
                        w_changed_nxt = 1'b1;
                        w_match_nxt   = '0;
                     end
                  end
               end else begin
                  w_match_nxt = '0;
                  w_miss_nxt  = w_miss_inc;
                  if (w_timeout && !w_freeze) begin
                     w_state_nxt   = ST_BLANK;
                     w_result_nxt  = BLANK_CODE;
                     w_valid_nxt   = 1'b0;
                     w_changed_nxt = (r_result != BLANK_CODE);
                     w_miss_nxt    = '0;
                  end
               end
            end

            default: begin
               w_state_nxt = ST_BLANK;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- output comb
   always_comb begin
      result         = r_result;
      result_valid   = r_valid;
      result_changed = r_changed;
   end

endmodule : digit_result_filter
`default_nettype wire

// File: doc/digit_result_filter.md
Name: digit_result_filter

Overview:
- Sits directly upstream of the seven-segment display driver and produces its 4-bit `result` input.
- Takes raw per-frame classifications from the recognition core, which can jitter frame to frame.
- Publishes a digit only after it has been stable for a set number of consecutive frames.
- Blanks the display (code F) after a run of frames with no detection.

Parameters:
- STABLE_CNT, 3: consecutive matching frames required to publish a new digit (legal 1..15).
- TIMEOUT_FRAMES, 30: consecutive no-detection frames before blanking (legal 0..255; 0 disables timeout).
- BLANK_CODE, 4'hF: value driven on result when no digit is published.

Ports:
- CLK_50M  input  1  system clock, 50 MHz.
- RST  input  1  reset; asynchronous, active-high.
- frame_end  input  1  one-cycle pulse marking the end of a recognition frame.
- det_valid  input  1  one-cycle pulse: the recognition core classified a digit in the current frame.
- det_digit  input  4  classified digit, sampled when det_valid=1.
- result  output  4  published digit, or BLANK_CODE; goes to the display driver.
- result_valid  output  1  1 while a digit is published.
- result_changed  output  1  one-cycle pulse whenever result changes value.

Behaviour:
- Reset (async assert, any cycle, including mid-frame) forces:
  - result=BLANK_CODE, result_valid=0, result_changed=0;
  - state=BLANK;
  - cand=0, match_cnt=0, miss_cnt=0, frame_has_det=0.
- Per-frame capture:
  - det_valid with det_digit<=9 sets frame_has_det=1 and frame_digit=det_digit.
  - If several det_valid pulses arrive in one frame, the last one wins.
  - det_digit>9 is ignored; it is not treated as a detection.
- det_valid in the same cycle as frame_end belongs to the ending frame.
- Capture registers clear on the cycle after frame_end.
- All evaluation happens only on frame_end. Outputs update one clock after the frame_end cycle.
- States: BLANK, LOCKED.
- BLANK:
  - Detection d: if d==cand, match_cnt+1; else cand=d, match_cnt=1.
  - When match_cnt reaches STABLE_CNT: go to LOCKED, result=d, result_valid=1, pulse result_changed, match_cnt=0.
  - No detection: match_cnt=0.
- LOCKED:
  - Detection d==result: miss_cnt=0, match_cnt=0.
  - Detection d!=result: miss_cnt=0, then run the candidate tracking rule above. On reaching STABLE_CNT: result=d, pulse result_changed, stay in LOCKED.
  - No detection: match_cnt=0, miss_cnt+1 (saturating at 255).
  - If TIMEOUT_FRAMES!=0 and miss_cnt reaches TIMEOUT_FRAMES: go to BLANK, result=BLANK_CODE, result_valid=0, pulse result_changed, miss_cnt=0.
- STABLE_CNT=1: the first detected frame publishes immediately.
- result_changed never asserts when the new value equals the old value.
- Frames without frame_end never advance counters. det_valid between frames accumulates into the next frame.

Optional Feature:
- Macro: DIGIT_RESULT_FREEZE_EN.
- When defined:
  - Adds input port `freeze` (1 bit).
  - While freeze=1: result, result_valid and state hold; no result_changed pulse.
  - Frame evaluation still updates cand, match_cnt and miss_cnt.
  - On release, a pending condition takes effect at the next frame_end, not retroactively.
- When undefined: no freeze port; behaviour exactly as above.

Decomposition:
- Shared package holds:
  - state enum (BLANK, LOCKED);
  - BLANK_CODE default 4'hF;
  - MAX_DIGIT constant 9;
  - counter width constants (match 4 bits, miss 8 bits).
- One natural sub-module: digit_frame_capture. It holds frame_has_det and frame_digit, applies the range check, and clears after frame_end. The parent holds the FSM and counters.

Test Plan:
- Reset mid-frame after det_valid(5) → result=F, result_valid=0; the next frame_end alone does not count the pre-reset digit.
- Three frames det_digit=7, STABLE_CNT=3 → result=7 and result_valid=1 one cycle after the 3rd frame_end; single result_changed pulse.
- Locked at 7, then frames 4,4,2,4,4,4 → result stays 7 until the 6th frame_end, then 4 with one pulse.
- Locked at 3, TIMEOUT_FRAMES=30: 29 empty frames → still 3; 30th → result=F, valid=0, pulse. A detection of 3 at frame 29 resets the miss count.
- det_valid(12) every frame for 5 frames → no change from BLANK. Two det_valid pulses (1 then 8) in one frame → 8 counted.
- With DIGIT_RESULT_FREEZE_EN, freeze=1 during the 3rd matching frame of 6 → result holds F. Release, then the next frame_end with 6 → result=6.
